// File: rtl/mio_pkg.sv
// mio_pkg: shared RAMCtrl codes, FSM states and lane helpers for the memory/IO bus unit.
package mio_pkg;
  typedef enum logic [2:0] {
    RC_FULL   = 3'd0,
    RC_FULLX  = 3'd1,
    RC_HALF   = 3'd2,
    RC_HALFX  = 3'd3,
    RC_HALFU  = 3'd4,
    RC_HALFUX = 3'd5
  } ram_ctrl_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  function automatic logic legal(input logic [2:0] m, input logic [1:0] a);
    return (m <= RC_FULLX) ? (a == 2'b00) : (m <= RC_HALFUX) ? !a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/mio_bus_unit_if.sv
// mio_bus_unit_if: RAM/peripheral bus handshake between the bus unit (master) and memory (slave).
interface mio_bus_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master(output req, we, addr, be, wdata, input rdata, ack);
  modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mio_lane_fmt.sv
// mio_lane_fmt: byte-enable and write-lane generation plus read extraction/extension.
module mio_lane_fmt import mio_pkg::*; (
  input  logic [2:0]  mode,
  input  logic        a1,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rfmt
);
  logic        full, swap, sext;
  logic [15:0] h, hs, ws;
  always_comb begin
    full  = (mode == RC_FULL) || (mode == RC_FULLX);
    swap  = (mode == RC_FULLX) || (mode == RC_HALFX) || (mode == RC_HALFUX);
    sext  = (mode == RC_HALF) || (mode == RC_HALFX);
    h     = a1 ? bus_rdata[31:16] : bus_rdata[15:0];
    hs    = swap ? {h[7:0], h[15:8]} : h;
    ws    = swap ? {wdata[7:0], wdata[15:8]} : wdata[15:0];
    be    = full ? 4'b1111 : a1 ? 4'b1100 : 4'b0011;
    wlane = full ? (swap ? bswap32(wdata) : wdata) : {ws, ws};
    rfmt  = full ? (swap ? bswap32(bus_rdata) : bus_rdata) : {{16{sext & hs[15]}}, hs};
  end
endmodule

// File: rtl/mio_bus_unit.sv
// mio_bus_unit: one-access-per-request bus handshake FSM with timeout between controller and RAM/IO bus.
module mio_bus_unit import mio_pkg::*; #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mio,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ram_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic        addr_err,
  output logic        bus_err,
  mio_bus_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  mode_q, mode_d;
  logic        a1_q, a1_d, rd_q, rd_d, we_q, we_d, aerr_q, aerr_d, berr_q, berr_d;
  logic [31:0] baddr_q, baddr_d, bwd_q, bwd_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  fmt_mode;
  logic        fmt_a1;
  logic [3:0]  f_be;
  logic [31:0] f_wdata, f_rdata;
  // Formatter sees live request fields in IDLE and the latched access while waiting for ack.
  assign fmt_mode = (state_q == S_IDLE) ? ram_ctrl : mode_q;
  assign fmt_a1   = (state_q == S_IDLE) ? addr[1] : a1_q;
  mio_lane_fmt u_fmt (
    .mode(fmt_mode), .a1(fmt_a1), .wdata(wdata), .bus_rdata(bus.rdata),
    .be(f_be), .wlane(f_wdata), .rfmt(f_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a1_d    = a1_q;
    rd_d    = rd_q;
    we_d    = we_q;
    aerr_d  = aerr_q;
    berr_d  = berr_q;
    baddr_d = baddr_q;
    bwd_d   = bwd_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (cpu_mio && (mem_read || mem_write)) begin
        aerr_d = !legal(ram_ctrl, addr[1:0]);
        berr_d = 1'b0;
        rd_d   = mem_read && !mem_write;
        if (aerr_d) begin
          state_d = S_DONE;
          rdata_d = rd_d ? '0 : rdata_q;
        end else begin
          state_d = S_REQ;
          cnt_d   = '0;
          mode_d  = ram_ctrl;
          a1_d    = addr[1];
          baddr_d = {addr[31:2], 2'b00};
          be_d    = f_be;
          we_d    = mem_write;
          bwd_d   = f_wdata;
        end
      end
      S_REQ: if (bus.ack) begin
        state_d = S_DONE;
        rdata_d = rd_q ? f_rdata : rdata_q;
      end else if (cnt_q == CW'(TIMEOUT)) begin
        state_d = S_DONE;
        berr_d  = 1'b1;
        rdata_d = rd_q ? '0 : rdata_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      a1_q    <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      baddr_q <= '0;
      bwd_q   <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a1_q    <= a1_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      baddr_q <= baddr_d;
      bwd_q   <= bwd_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.req   = (state_q == S_REQ);
  assign bus.we    = we_q;
  assign bus.addr  = baddr_q;
  assign bus.be    = be_q;
  assign bus.wdata = bwd_q;
  assign mio_ready = (state_q == S_DONE);
  assign addr_err  = aerr_q;
  assign bus_err   = berr_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_mio_bus_unit.sv
// tb_mio_bus_unit: directed accesses with a response scoreboard and a bus-side slave/monitor.
module tb_mio_bus_unit;
  import mio_pkg::*;
  logic        clk = 1'b0, rst = 1'b0, cpu_mio = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  ram_ctrl = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        mio_ready, addr_err, bus_err;
  mio_bus_unit_if bus();
  mio_bus_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_read(mem_read), .mem_write(mem_write),
    .ram_ctrl(ram_ctrl), .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
    .addr_err(addr_err), .bus_err(bus_err), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] rdata; logic aerr; logic berr;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we;} bexp_t;
  resp_t exp_q[$];
  bexp_t bexp_q[$];
  int checks = 0, failures = 0;
  int ack_delay = 0, waitc = 0, req_cycles = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // Bus slave: acks on the (ack_delay+1)th REQ cycle and checks the request fields on its first cycle.
  always @(negedge clk) begin
    bexp_t b;
    if (bus.req) begin
      if (waitc == 0) begin
        if (bexp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexp actual=req expected=no_req addr=%h", bus.addr);
        end else begin
          b = bexp_q.pop_front();
          chk("bus_addr", bus.addr, b.addr);
          chk("bus_wdata", bus.wdata, b.wdata);
          chk("bus_be", {28'd0, bus.be}, {28'd0, b.be});
          chk("bus_we", {31'd0, bus.we}, {31'd0, b.we});
        end
      end
      bus.ack = (waitc == ack_delay);
      waitc++;
      req_cycles++;
    end else begin
      waitc = 0;
      bus.ack = 1'b0;
    end
  end
  always @(negedge clk) begin
    resp_t e;
    if (mio_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ready_unexp actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
      end
    end
  end
  task automatic access(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] brd, input logic rd, input logic wr, input int d,
                        input logic [31:0] erd, input logic eaerr, input logic eberr,
                        input logic [3:0] ebe, input logic [31:0] ewd, input int elat, input int ereq);
    resp_t r;
    bexp_t b;
    int n;
    @(posedge clk);
    #1;
    r.rdata = erd;
    r.aerr  = eaerr;
    r.berr  = eberr;
    exp_q.push_back(r);
    if (!eaerr) begin
      b.addr  = {a[31:2], 2'b00};
      b.wdata = ewd;
      b.be    = ebe;
      b.we    = wr;
      bexp_q.push_back(b);
    end
    ack_delay = d;
    req_cycles = 0;
    bus.rdata = brd;
    ram_ctrl = m;
    addr = a;
    wdata = wd;
    mem_read = rd;
    mem_write = wr;
    cpu_mio = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mio_ready && n < 20);
    cpu_mio = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk("latency", n, elat);
    chk("req_cycles", req_cycles, ereq);
  endtask
  initial begin
    bus.ack = 1'b0;
    bus.rdata = '0;
    #2;
    chk("rst_ready", {31'd0, mio_ready}, 0);
    chk("rst_req", {31'd0, bus.req}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_errs", {30'd0, addr_err, bus_err}, 0);
    chk("rst_bus", {bus.addr | bus.wdata}, 0);
    chk("rst_be_we", {27'd0, bus.be, bus.we}, 0);
    #10 rst = 1'b1;
    access(RC_FULL,   32'h10, 32'h0,        32'h11223344, 1, 0, 0,   32'h11223344, 0, 0, 4'hF, 32'h0,        2, 1);
    access(RC_HALFX,  32'h12, 32'h0,        32'h80F11234, 1, 0, 0,   32'hFFFFF180, 0, 0, 4'hC, 32'h0,        2, 1);
    access(RC_HALFUX, 32'h12, 32'h0,        32'h80F11234, 1, 0, 1,   32'h0000F180, 0, 0, 4'hC, 32'h0,        3, 2);
    access(RC_HALF,   32'h22, 32'h0000ABCD, 32'h0,        0, 1, 0,   32'h0000F180, 0, 0, 4'hC, 32'hABCDABCD, 2, 1);
    access(RC_FULL,   32'h03, 32'h0,        32'h55555555, 1, 0, 0,   32'h0,        1, 0, 4'h0, 32'h0,        1, 0);
    access(RC_FULLX,  32'h40, 32'h11223344, 32'h0,        0, 1, 2,   32'h0,        0, 0, 4'hF, 32'h44332211, 4, 3);
    access(RC_FULLX,  32'h44, 32'h0,        32'hAABBCCDD, 1, 0, 0,   32'hDDCCBBAA, 0, 0, 4'hF, 32'h0,        2, 1);
    access(RC_HALF,   32'h16, 32'h0,        32'h7FFF8001, 1, 0, 0,   32'h00007FFF, 0, 0, 4'hC, 32'h0,        2, 1);
    access(RC_HALFU,  32'h14, 32'h0,        32'h1234ABCD, 1, 0, 0,   32'h0000ABCD, 0, 0, 4'h3, 32'h0,        2, 1);
    access(RC_HALF,   32'h14, 32'h0,        32'h1234ABCD, 1, 0, 0,   32'hFFFFABCD, 0, 0, 4'h3, 32'h0,        2, 1);
    access(RC_FULL,   32'h50, 32'h0,        32'h0,        1, 0, 100, 32'h0,        0, 1, 4'hF, 32'h0,        6, 5);
    access(RC_FULL,   32'h54, 32'h0,        32'hCAFEBABE, 1, 0, 4,   32'hCAFEBABE, 0, 0, 4'hF, 32'h0,        6, 5);
    access(3'd6,      32'h0,  32'h0,        32'h0,        1, 0, 0,   32'h0,        1, 0, 4'h0, 32'h0,        1, 0);
    access(RC_FULL,   32'h58, 32'h0,        32'h0BADF00D, 1, 0, 0,   32'h0BADF00D, 0, 0, 4'hF, 32'h0,        2, 1);
    access(RC_FULL,   32'h60, 32'hDEADBEEF, 32'h12345678, 1, 1, 0,   32'h0BADF00D, 0, 0, 4'hF, 32'hDEADBEEF, 2, 1);
    access(RC_FULLX,  32'h02, 32'h1,        32'h0,        0, 1, 0,   32'h0BADF00D, 1, 0, 4'h0, 32'h0,        1, 0);
    access(RC_HALF,   32'h11, 32'h0,        32'h0,        1, 0, 0,   32'h0,        1, 0, 4'h0, 32'h0,        1, 0);
    access(RC_HALFX,  32'h00, 32'h0000ABCD, 32'h0,        0, 1, 0,   32'h0,        0, 0, 4'h3, 32'hCDABCDAB, 2, 1);
    access(RC_FULL,   32'h68, 32'h0,        32'h600DCAFE, 1, 0, 0,   32'h600DCAFE, 0, 0, 4'hF, 32'h0,        2, 1);
    // Reset in the middle of a REQ wait must drop bus_req without a clock edge.
    @(posedge clk);
    #1;
    begin
      bexp_t b;
      b.addr = 32'h70;
      b.wdata = 32'h0;
      b.be = 4'hF;
      b.we = 1'b0;
      bexp_q.push_back(b);
    end
    ack_delay = 100;
    ram_ctrl = RC_FULL;
    addr = 32'h70;
    wdata = 32'h0;
    mem_read = 1'b1;
    cpu_mio = 1'b1;
    @(posedge clk);
    #1;
    cpu_mio = 1'b0;
    mem_read = 1'b0;
    chk("req_before_rst", {31'd0, bus.req}, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("req_async_rst", {31'd0, bus.req}, 0);
    chk("rdata_async_rst", rdata, 0);
    chk("ready_async_rst", {31'd0, mio_ready}, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    access(RC_FULL,   32'h74, 32'h0,        32'h13579BDF, 1, 0, 0,   32'h13579BDF, 0, 0, 4'hF, 32'h0,        2, 1);
    repeat (3) @(posedge clk);
    chk("resp_left", exp_q.size(), 0);
    chk("bus_left", bexp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mio_bus_unit.md
# mio_bus_unit

Memory/IO bus interface between the multicycle controller/datapath and the RAM/peripheral bus. It accepts one access per request from the controller (`CPU_MIO`, `MemRead`, `MemWrite`, `RAMCtrl`) and performs the bus handshake. It formats byte lanes for word and half-word accesses, including byte-swapped and sign/zero-extended variants. It returns `MIO_ready` to the controller, which stalls until it sees that pulse.

## Interface
- `TIMEOUT`, default 255: number of `REQ` cycles without `bus_ack` before the access is aborted with `bus_err`.
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `cpu_mio`  in  1: access request qualifier.
- `mem_read`  in  1: read request.
- `mem_write`  in  1: write request.
- `ram_ctrl`  in  3: access mode: Full, Fullx, Half, Halfx, Halfu, Halfux.
- `addr`  in  32: byte address from the datapath.
- `wdata`  in  32: store data (register B).
- `rdata`  out  32: formatted load data.
- `mio_ready`  out  1: one-cycle completion pulse.
- `addr_err`  out  1: misaligned access or illegal mode; valid with `mio_ready`.
- `bus_err`  out  1: timeout; valid with `mio_ready`.
- `bus_req`  out  1: bus request.
- `bus_we`  out  1: bus write enable.
- `bus_addr`  out  32: word-aligned bus address (`addr[31:2],2'b00`).
- `bus_be`  out  4: byte enables; bit i covers `[8i+7:8i]`.
- `bus_wdata`  out  32: bus write data.
- `bus_rdata`  in  32: bus read data.
- `bus_ack`  in  1: bus completion.

## Operation
- FSM states and transitions:
  - `IDLE`: on `cpu_mio & (mem_read|mem_write)`, go to `REQ` if legal, else to `DONE` with `addr_err=1`.
  - `REQ`: on `bus_ack`, go to `DONE`; on timeout, go to `DONE` with `bus_err=1`.
  - `DONE`: always go to `IDLE`.
- Legality:
  - Full/Fullx require `addr[1:0]==0`.
  - Half modes require `addr[0]==0`.
  - `ram_ctrl` codes 6 and 7 are illegal.
- `mem_read & mem_write` together: treated as a write; no read data is captured.
- Byte enables:
  - Full: `1111`.
  - Half: `0011` if `addr[1]==0`, else `1100`.
- Write data:
  - Full: `wdata`.
  - Fullx: `wdata` byte-reversed.
  - Half: `{wdata[15:0], wdata[15:0]}`.
  - Halfx: the same, with the two bytes of the half swapped.
- Read data:
  - Full: `bus_rdata`.
  - Fullx: `bus_rdata` byte-reversed.
  - Half modes: select `h = addr[1] ? [31:16] : [15:0]`. The x variants swap the bytes of `h`. Half/Halfx sign-extend; Halfu/Halfux zero-extend.
- `rdata` is captured on the `REQ`→`DONE` ack edge. It holds until the next successful read and is 0 after a `bus_err` or `addr_err` read.
- `addr_err` and `bus_err` are cleared when the next request is accepted.
- Requester rule: the request must deassert in the cycle after `mio_ready`. A request still present in `IDLE` is accepted as a new access.

## Timing
- Reset values (asynchronous, immediate): state `IDLE`; all outputs 0, including `bus_req`. A reset during `REQ` abandons the access.
- `bus_addr`, `bus_be`, `bus_we`, `bus_wdata` are registered at acceptance and held stable throughout `REQ`.
- `bus_req` = (state==`REQ`). `mio_ready` = (state==`DONE`). Both are Moore outputs.
- Minimum latency: request seen in cycle 0, `REQ` in cycle 1 with ack, `mio_ready` in cycle 2.
- Each wait cycle without ack adds one cycle.
- Illegal access: `mio_ready` in cycle 1, with no bus activity.
- Timeout counter is cleared on entry to `REQ` and increments each `REQ` cycle without ack. When it equals `TIMEOUT`, the next state is `DONE` with `bus_err`. If ack arrives on that same cycle, ack wins and `bus_err=0`.

## Structure
- Shared package `mio_pkg`: `ram_ctrl` codes (Full=0, Fullx=1, Half=2, Halfx=3, Halfu=4, Halfux=5), FSM state encoding, byte-swap helper function. `mips_parameters.vh` uses the same RAMCtrl values.
- Sub-module `mio_lane_fmt`: combinational write-lane/byte-enable generation and read extraction/extension. The FSM, counter and registers stay in `mio_bus_unit`.

## Test plan
- Full read, addr `0x10`, `bus_rdata=0x11223344`, ack in the first `REQ` cycle → `mio_ready` in cycle 2, `rdata=0x11223344`.
- Halfx read, addr `0x12`, `bus_rdata=0x80F11234` → `rdata=0xFFFFF180`. Halfux from the same address → `0x0000F180`.
- Half write, addr `0x22`, `wdata=0x0000ABCD` → `bus_be=1100`, `bus_wdata=0xABCDABCD`, `bus_addr=0x20`, `bus_we=1`.
- Full read at addr `0x03` → `addr_err=1` with `mio_ready` in cycle 1, `bus_req` never asserted, `rdata=0`.
- `TIMEOUT=4`, no ack → `bus_req` high for 5 cycles, then `mio_ready` with `bus_err=1`. Repeat with ack on the 5th cycle → `bus_err=0`.
- `rst` asserted low mid-`REQ` → `bus_req` drops without a clock edge. After release, a new Full read completes normally.
